mbe_r8_mult_pipe: RTL and testbench

- Parametrised, pipelined Modified-Booth radix-8 multiplier for the FP datapath mantissa multiply and for general integer multiply.
- Generalises the combinational 24-bit top: any operand width, selectable register depth, per-transaction signed/unsigned mode, and a sideband tag.
- valid/ready handshake on both sides, with full backpressure.
- Chain: Booth encode -> PP generation/select -> sign-reduction -> compression tree -> final adder.

---
 rtl/mbe_r8_mult_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_mbe_r8_mult_pipe.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbe_r8_mult_pipe.sv
// Pipelined Modified-Booth radix-8 multiplier: Booth encode, PP select, sign-constant
// compression to a carry-save pair, then a final adder, with valid/ready backpressure.
module mbe_r8_mult_pipe #(
    parameter int unsigned NBIT        = 24,
    parameter int unsigned PIPE_STAGES = 3,
    parameter int unsigned TAG_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBIT-1:0]     in_x,
    input  logic [NBIT-1:0]     in_y,
    input  logic                in_signed,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*NBIT-1:0]   out_product,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int NE     = NBIT + 1;
    localparam int NBLOCK = (NE + 2) / 3;
    localparam int PW     = 2 * NBIT;
    localparam int RW     = NBIT + 3;
    localparam int YW     = 3 * NBLOCK + 1;

    // Returns {neg, sel4, sel3, sel2, sel1} for a window {y[3i+2], y[3i+1], y[3i], y[3i-1]}.
    function automatic logic [4:0] booth_enc(input logic [3:0] b);
        logic [4:0] enc;
        case (b)
            4'b0000, 4'b1111: enc = 5'b0_0000;
            4'b0001, 4'b0010: enc = 5'b0_0001;
            4'b0011, 4'b0100: enc = 5'b0_0010;
            4'b0101, 4'b0110: enc = 5'b0_0100;
            4'b0111:          enc = 5'b0_1000;
            4'b1000:          enc = 5'b1_1000;
            4'b1001, 4'b1010: enc = 5'b1_0100;
            4'b1011, 4'b1100: enc = 5'b1_0010;
            4'b1101, 4'b1110: enc = 5'b1_0001;
            default:          enc = 5'b0_0000;
        endcase
        return enc;
    endfunction

    // Each row's sign bit is inverted; subtracting 2^(RW-1) per row restores the
    // sign-extended value, so all of those corrections fold into one constant.
    function automatic logic [PW-1:0] sign_const();
        logic [PW-1:0] k;
        logic [PW-1:0] one;
        k   = '0;
        one = {{(PW-1){1'b0}}, 1'b1};
        for (int i = 0; i < NBLOCK; i++) begin
            k = k - (one << (RW - 1 + 3 * i));
        end
        return k;
    endfunction

    localparam logic [PW-1:0] SIGN_K = sign_const();

    logic w_adv;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv & rst_n;

    logic                   w_sx;
    logic                   w_sy;
    logic [RW-1:0]          w_x1;
    logic [RW-1:0]          w_x2;
    logic [RW-1:0]          w_x3;
    logic [RW-1:0]          w_x4;
    logic [YW-1:0]          w_yb;
    logic [NBLOCK*RW-1:0]   w_rows;
    logic [NBLOCK-1:0]      w_neg;

    assign w_sx = in_signed & in_x[NBIT-1];
    assign w_sy = in_signed & in_y[NBIT-1];
    assign w_x1 = {{3{w_sx}}, in_x};
    assign w_x2 = {w_x1[RW-2:0], 1'b0};
    assign w_x4 = {w_x1[RW-3:0], 2'b00};
    assign w_x3 = w_x1 + w_x2;
    assign w_yb = {{(YW - 1 - NBIT){w_sy}}, in_y, 1'b0};

    always_comb begin
        logic [4:0]    enc;
        logic [RW-1:0] pp;
        enc    = '0;
        pp     = '0;
        w_rows = '0;
        w_neg  = '0;
        for (int i = 0; i < NBLOCK; i++) begin
            enc = booth_enc(w_yb[3*i +: 4]);
            pp  = ({RW{enc[0]}} & w_x1) | ({RW{enc[1]}} & w_x2) |
                  ({RW{enc[2]}} & w_x3) | ({RW{enc[3]}} & w_x4);
            // One's complement here; the +1 is injected as a correction bit in the tree.
            pp  = pp ^ {RW{enc[4]}};
            w_rows[i*RW +: RW] = {~pp[RW-1], pp[RW-2:0]};
            w_neg[i]           = enc[4];
        end
    end

    // The signed mode is folded into the extended operands here, so only data and tag
    // need to ride through the later boundaries.
    logic [NBLOCK*RW-1:0]   w_a_rows;
    logic [NBLOCK-1:0]      w_a_neg;
    logic [TAG_W-1:0]       w_a_tag;
    logic                   w_a_valid;

    if (PIPE_STAGES >= 3) begin : g_reg_a
        logic [NBLOCK*RW-1:0]   r_a_rows;
        logic [NBLOCK-1:0]      r_a_neg;
        logic [TAG_W-1:0]       r_a_tag;
        logic                   r_a_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_valid <= 1'b0;
                r_a_rows  <= '0;
                r_a_neg   <= '0;
                r_a_tag   <= '0;
            end else if (w_adv) begin
                r_a_valid <= in_valid;
                r_a_rows  <= w_rows;
                r_a_neg   <= w_neg;
                r_a_tag   <= in_tag;
            end
        end

        assign w_a_rows  = r_a_rows;
        assign w_a_neg   = r_a_neg;
        assign w_a_tag   = r_a_tag;
        assign w_a_valid = r_a_valid;
    end else begin : g_bypass_a
        assign w_a_rows  = w_rows;
        assign w_a_neg   = w_neg;
        assign w_a_tag   = in_tag;
        assign w_a_valid = in_valid;
    end

    logic [PW-1:0] w_sum;
    logic [PW-1:0] w_carry;

    always_comb begin
        logic [PW-1:0] row;
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] ns;
        logic [PW-1:0] nc;
        s   = SIGN_K;
        c   = '0;
        row = '0;
        ns  = '0;
        nc  = '0;
        for (int i = 0; i < NBLOCK; i++) begin
            c[3*i] = w_a_neg[i];
        end
        for (int i = 0; i < NBLOCK; i++) begin
            row = {{(PW - RW){1'b0}}, w_a_rows[i*RW +: RW]} << (3 * i);
            ns  = s ^ c ^ row;
            nc  = ((s & c) | (s & row) | (c & row)) << 1;
            s   = ns;
            c   = nc;
        end
        w_sum   = s;
        w_carry = c;
    end

    logic [PW-1:0]      w_b_sum;
    logic [PW-1:0]      w_b_carry;
    logic [TAG_W-1:0]   w_b_tag;
    logic               w_b_valid;

    if (PIPE_STAGES >= 2) begin : g_reg_b
        logic [PW-1:0]      r_b_sum;
        logic [PW-1:0]      r_b_carry;
        logic [TAG_W-1:0]   r_b_tag;
        logic               r_b_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_b_valid <= 1'b0;
                r_b_sum   <= '0;
                r_b_carry <= '0;
                r_b_tag   <= '0;
            end else if (w_adv) begin
                r_b_valid <= w_a_valid;
                r_b_sum   <= w_sum;
                r_b_carry <= w_carry;
                r_b_tag   <= w_a_tag;
            end
        end

        assign w_b_sum   = r_b_sum;
        assign w_b_carry = r_b_carry;
        assign w_b_tag   = r_b_tag;
        assign w_b_valid = r_b_valid;
    end else begin : g_bypass_b
        assign w_b_sum   = w_sum;
        assign w_b_carry = w_carry;
        assign w_b_tag   = w_a_tag;
        assign w_b_valid = w_a_valid;
    end

    logic               r_c_valid;
    logic [PW-1:0]      r_c_product;
    logic [TAG_W-1:0]   r_c_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_valid   <= 1'b0;
            r_c_product <= '0;
            r_c_tag     <= '0;
        end else if (w_adv) begin
            r_c_valid   <= w_b_valid;
            r_c_product <= w_b_sum + w_b_carry;
            r_c_tag     <= w_b_tag;
        end
    end

    assign out_valid   = r_c_valid;
    assign out_product = r_c_product;
    assign out_tag     = r_c_tag;

endmodule

// File: tb/tb_mbe_r8_mult_pipe.sv
// Scoreboard bench for mbe_r8_mult_pipe: directed vectors, stream, backpressure and reset
// on a 24-bit/3-stage instance, plus a width/depth sweep with latency checks.
module tb_mbe_r8_mult_pipe;

    localparam int NCFG = 6;

    function automatic int cfg_nb(input int g);
        case (g)
            0: return 4;
            1: return 4;
            2: return 8;
            3: return 11;
            4: return 24;
            default: return 53;
        endcase
    endfunction

    function automatic int cfg_ps(input int g);
        case (g)
            0: return 1;
            1: return 3;
            2: return 2;
            3: return 3;
            4: return 1;
            default: return 2;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_wait = 0;
    int sw_done_cnt = 0;
    logic sw_rst_n = 1'b0;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_x;
    logic [23:0] in_y;
    logic        in_signed;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_product;
    logic [3:0]  out_tag;

    mbe_r8_mult_pipe #(.NBIT(24), .PIPE_STAGES(3), .TAG_W(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_signed   (in_signed),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag)
    );

    typedef struct packed {
        logic [47:0] p;
        logic [3:0]  t;
    } exp_t;

    exp_t main_q[$];
    exp_t mon_e;

    function automatic logic [47:0] ref24(input logic [23:0] x, input logic [23:0] y,
                                          input logic s);
        logic signed [63:0] ax;
        logic signed [63:0] ay;
        ax = {{40{s & x[23]}}, x};
        ay = {{40{s & y[23]}}, y};
        return 48'(ax * ay);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [23:0] x, input logic [23:0] y, input logic s,
                        input logic [3:0] t, input logic [47:0] e);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_signed = s;
        in_tag    = t;
        for (int w = 0; w < 60 && !done; w++) begin
            #1;
            if (in_ready) begin
                main_q.push_back('{p: e, t: t});
                n_acc++;
                @(posedge clk);
                done = 1'b1;
            end else begin
                n_wait++;
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout tag=%0d actual=not_accepted required=accepted", t);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40 && main_q.size() != 0; k++) @(negedge clk);
        chk(name, 64'(main_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (main_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output actual=%h required=no_output", out_product);
            end else begin
                mon_e = main_q.pop_front();
                chk("product", 64'(out_product), 64'(mon_e.p));
                chk("tag", 64'(out_tag), 64'(mon_e.t));
            end
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_sw
        localparam int NB   = cfg_nb(g);
        localparam int PS   = cfg_ps(g);
        localparam bit EXH  = (NB <= 4);
        localparam int NVEC = EXH ? (1 << (2 * NB)) : 150;

        typedef struct packed {
            logic [2*NB-1:0] p;
            logic [3:0]      t;
            logic [31:0]     c;
        } sw_exp_t;

        sw_exp_t q[$];
        sw_exp_t e;

        logic            s_valid;
        logic            s_ready;
        logic            s_sgn;
        logic            o_valid;
        logic [NB-1:0]   s_x;
        logic [NB-1:0]   s_y;
        logic [3:0]      s_tag;
        logic [3:0]      o_tag;
        logic [2*NB-1:0] o_prod;

        mbe_r8_mult_pipe #(.NBIT(NB), .PIPE_STAGES(PS), .TAG_W(4)) u_dut (
            .clk         (clk),
            .rst_n       (sw_rst_n),
            .in_valid    (s_valid),
            .in_ready    (s_ready),
            .in_x        (s_x),
            .in_y        (s_y),
            .in_signed   (s_sgn),
            .in_tag      (s_tag),
            .out_valid   (o_valid),
            .out_ready   (1'b1),
            .out_product (o_prod),
            .out_tag     (o_tag)
        );

        function automatic logic [2*NB-1:0] model(input logic [NB-1:0] x,
                                                  input logic [NB-1:0] y, input logic s);
            logic signed [127:0] ax;
            logic signed [127:0] ay;
            ax = {{(128 - NB){s & x[NB-1]}}, x};
            ay = {{(128 - NB){s & y[NB-1]}}, y};
            return (2 * NB)'(ax * ay);
        endfunction

        task automatic sw_send(input logic [NB-1:0] x, input logic [NB-1:0] y,
                               input logic s, input logic [3:0] t);
            @(negedge clk);
            s_valid = 1'b1;
            s_x     = x;
            s_y     = y;
            s_sgn   = s;
            s_tag   = t;
            #1;
            n_cmp++;
            if (s_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL sw%0d_in_ready actual=%b required=1", g, s_ready);
            end else begin
                q.push_back('{p: model(x, y, s), t: t, c: cyc});
            end
            @(posedge clk);
        endtask

        initial begin
            logic [NB-1:0] x;
            logic [NB-1:0] y;
            logic [NB-1:0] cmax;
            logic [NB-1:0] cmsb;
            s_valid = 1'b0;
            s_x     = '0;
            s_y     = '0;
            s_sgn   = 1'b0;
            s_tag   = '0;
            cmax    = '1;
            cmsb    = '0;
            cmsb[NB-1] = 1'b1;
            wait (sw_rst_n);
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < NVEC; k++) begin
                    if (EXH) begin
                        x = NB'(k >> NB);
                        y = NB'(k);
                    end else if (k == 0) begin
                        x = cmax;
                        y = cmax;
                    end else if (k == 1) begin
                        x = cmsb;
                        y = cmsb;
                    end else if (k == 2) begin
                        x = cmax;
                        y = NB'(3);
                    end else if (k == 3) begin
                        x = cmsb;
                        y = cmax;
                    end else begin
                        x = NB'({$urandom, $urandom});
                        y = NB'({$urandom, $urandom});
                    end
                    sw_send(x, y, (m == 1), 4'(k));
                end
            end
            @(negedge clk);
            s_valid = 1'b0;
            for (int k = 0; k < PS + 8 && q.size() != 0; k++) @(negedge clk);
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL sw%0d_drain actual=%0d left required=0", g, q.size());
            end
            sw_done_cnt++;
        end

        always @(negedge clk) begin
            #2;
            if (sw_rst_n && o_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sw%0d_unexpected actual=%h required=no_output", g, o_prod);
                end else begin
                    e = q.pop_front();
                    n_cmp += 3;
                    if (o_prod !== e.p) begin
                        n_bad++;
                        $display("FAIL sw%0d_product actual=%h required=%h", g, o_prod, e.p);
                    end
                    if (o_tag !== e.t) begin
                        n_bad++;
                        $display("FAIL sw%0d_tag actual=%h required=%h", g, o_tag, e.t);
                    end
                    if ((cyc - e.c) !== 32'(PS)) begin
                        n_bad++;
                        $display("FAIL sw%0d_latency actual=%0d required=%0d", g, cyc - e.c, PS);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        int wait0;
        int late;
        logic [23:0] rx;
        logic [23:0] ry;
        logic        rs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_product", 64'(out_product), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        send(24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'd0,  48'hFFFFFE000001);
        send(24'h000000, 24'hABCDEF, 1'b0, 4'd1,  48'h000000000000);
        send(24'hFFFFFF, 24'h000003, 1'b1, 4'd2,  48'hFFFFFFFFFFFD);
        send(24'h800000, 24'h800000, 1'b1, 4'd3,  48'h400000000000);
        send(24'h800000, 24'h800000, 1'b0, 4'd4,  48'h400000000000);
        send(24'hFFFFFF, 24'h000003, 1'b0, 4'd5,  48'h000002FFFFFD);
        send(24'h7FFFFF, 24'h7FFFFF, 1'b1, 4'd6,  48'h3FFFFF000001);
        send(24'h800000, 24'h7FFFFF, 1'b1, 4'd7,  48'hC00000800000);
        send(24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'd8,  48'h000000000001);
        send(24'h123456, 24'h000010, 1'b0, 4'd9,  48'h000001234560);
        send(24'hABCDEF, 24'h000000, 1'b1, 4'd10, 48'h000000000000);
        send(24'h800000, 24'hFFFFFF, 1'b1, 4'd11, 48'h000000800000);
        send(24'h800000, 24'hFFFFFF, 1'b0, 4'd12, 48'h7FFFFF800000);
        idle();
        wait_drain("directed_drain");

        wait0 = n_wait;
        for (int i = 0; i < 100; i++) begin
            rx = 24'($urandom);
            ry = 24'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(rx, ry, rs, 4'(i), ref24(rx, ry, rs));
        end
        idle();
        chk("stream_stalls", 64'(n_wait - wait0), 64'd0);
        wait_drain("stream_drain");

        @(negedge clk);
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send(24'd1, 24'd2, 1'b0, 4'd0, 48'd2);
                send(24'd2, 24'd3, 1'b0, 4'd1, 48'd6);
                send(24'd3, 24'd4, 1'b0, 4'd2, 48'd12);
                send(24'd4, 24'd5, 1'b0, 4'd3, 48'd20);
                send(24'd5, 24'd6, 1'b0, 4'd4, 48'd30);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                #1;
                chk("bp_accepted", 64'(n_acc - acc0), 64'd3);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_product", 64'(out_product), 64'd2);
                repeat (3) @(negedge clk);
                #1;
                chk("bp_product_held", 64'(out_product), 64'd2);
                chk("bp_tag_held", 64'(out_tag), 64'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");

        send(24'h000002, 24'h000003, 1'b0, 4'd1, 48'd6);
        send(24'h000004, 24'h000005, 1'b0, 4'd2, 48'd20);
        send(24'h000006, 24'h000007, 1'b0, 4'd3, 48'd42);
        #1;
        chk("rst_pre_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        main_q.delete();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_product", 64'(out_product), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        late = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) late++;
        end
        chk("rst_no_stale", 64'(late), 64'd0);

        send(24'h7FFFFF, 24'h7FFFFF, 1'b1, 4'd5, 48'h3FFFFF000001);
        idle();
        wait_drain("final_drain");

        for (int k = 0; k < 3000 && sw_done_cnt < NCFG; k++) @(negedge clk);
        chk("sweep_done", 64'(sw_done_cnt), 64'(NCFG));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
